mips_ctrl_pipe: RTL and testbench

Parametrised main-control unit for the five-stage pipelined MIPS core. It decodes the opcode in the Decode stage and delivers branch/jump controls combinationally to Decode. All datapath controls travel through registered Execute, Memory and Writeback control stages. The pipeline stages support stall and flush. Illegal opcodes are decoded to a bubble and counted.

---
 rtl/mips_ctrl_pipe_if.sv | 70 +++++++
 rtl/mips_ctrl_pipe.sv | 249 ++++++++++++++++++++++++
 tb/tb_mips_ctrl_pipe.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pipe_if
//  Description : Control bundle between the Decode-stage instruction source
//                and the pipelined main-control unit. The master side drives
//                the opcode and pipeline hazard controls. The slave side
//                returns the Decode branch/jump strobes, the staged controls
//                and the illegal-opcode status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_ctrl_pipe_if #(
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 8
);
  // Width of the ALU class field. It is wider when the extended ops are built in.
  localparam int ALUOP_W = (EXT_OPS != 0) ? 3 : 2;

  // Decode-side inputs to the control unit
  logic [5:0]         op_d;
  logic               stall_e;
  logic               flush_e;
  logic               clr_err;

  // Combinational Decode controls
  logic               branch_d;
  logic               bne_d;
  logic               jump_d;
  logic               illegal_d;

  // Execute stage controls
  logic               regwrite_e;
  logic               memtoreg_e;
  logic               memwrite_e;
  logic               alusrc_e;
  logic               regdst_e;
  logic               zeroext_e;
  logic [ALUOP_W-1:0] aluop_e;

  // Memory stage controls
  logic               regwrite_m;
  logic               memtoreg_m;
  logic               memwrite_m;

  // Writeback stage controls
  logic               regwrite_w;
  logic               memtoreg_w;

  // Illegal-opcode status
  logic               illegal_seen;
  logic [CNT_W-1:0]   illegal_cnt;

  modport master (
    output op_d, stall_e, flush_e, clr_err,
    input  branch_d, bne_d, jump_d, illegal_d,
    input  regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroext_e, aluop_e,
    input  regwrite_m, memtoreg_m, memwrite_m,
    input  regwrite_w, memtoreg_w,
    input  illegal_seen, illegal_cnt
  );

  modport slave (
    input  op_d, stall_e, flush_e, clr_err,
    output branch_d, bne_d, jump_d, illegal_d,
    output regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e, zeroext_e, aluop_e,
    output regwrite_m, memtoreg_m, memwrite_m,
    output regwrite_w, memtoreg_w,
    output illegal_seen, illegal_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mips_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pipe
//  Description : Main control unit for the five-stage MIPS pipeline. It
//                decodes the opcode in Decode and gives the branch/jump
//                strobes straight back to Decode. The datapath controls then
//                travel through registered E, M and W stages, which support
//                stall and flush. Any unsupported opcode decodes to an all-zero
//                bubble. It is also recorded in a sticky flag and a saturating
//                counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_pipe #(
  parameter int EXT_OPS = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active-low
  mips_ctrl_pipe_if.slave  bus
);

  localparam int ALUOP_W = (EXT_OPS != 0) ? 3 : 2;

  // Opcode encodings
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  // The 2-bit ALU class codes are the low bits of the 3-bit codes.
  // Narrowing with a cast lets one decode table serve both widths.
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3'b111);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regdst;
    logic               zeroext;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_e_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } ctrl_m_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } ctrl_w_t;

  // Decode results
  ctrl_e_t          dec_ctrl;
  logic             dec_branch;
  logic             dec_bne;
  logic             dec_jump;
  logic             dec_illegal;
  logic             illegal_evt;

  // Pipeline registers and their next states
  ctrl_e_t          e_q, e_d;
  ctrl_m_t          m_q, m_d;
  ctrl_w_t          w_q, w_d;

  // Error tracking registers and their next states
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Main decoder. The default is an illegal bubble. Each supported opcode clears illegal.
  always_comb begin
    dec_ctrl    = '0;
    dec_branch  = 1'b0;
    dec_bne     = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b1;
    case (bus.op_d)
      OP_RTYPE: begin
        dec_illegal       = 1'b0;
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.regdst   = 1'b1;
        dec_ctrl.aluop    = ALU_FUNC;
      end
      OP_LW: begin
        dec_illegal       = 1'b0;
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.memtoreg = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.aluop    = ALU_ADD;
      end
      OP_SW: begin
        dec_illegal       = 1'b0;
        dec_ctrl.memwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        dec_illegal    = 1'b0;
        dec_branch     = 1'b1;
        dec_ctrl.aluop = ALU_SUB;
      end
      OP_ADDI: begin
        dec_illegal       = 1'b0;
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.aluop    = ALU_ADD;
      end
      // Extended ops stay illegal unless the extended set is built in.
      OP_J: begin
        if (EXT_OPS != 0) begin
          dec_illegal = 1'b0;
          dec_jump    = 1'b1;
        end
      end
      OP_BNE: begin
        if (EXT_OPS != 0) begin
          dec_illegal    = 1'b0;
          dec_bne        = 1'b1;
          dec_ctrl.aluop = ALU_SUB;
        end
      end
      OP_ANDI: begin
        if (EXT_OPS != 0) begin
          dec_illegal       = 1'b0;
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.zeroext  = 1'b1;
          dec_ctrl.aluop    = ALU_AND;
        end
      end
      OP_ORI: begin
        if (EXT_OPS != 0) begin
          dec_illegal       = 1'b0;
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.zeroext  = 1'b1;
          dec_ctrl.aluop    = ALU_OR;
        end
      end
      OP_SLTI: begin
        if (EXT_OPS != 0) begin
          dec_illegal       = 1'b0;
          dec_ctrl.regwrite = 1'b1;
          dec_ctrl.alusrc   = 1'b1;
          dec_ctrl.aluop    = ALU_SLT;
        end
      end
      default: begin
      end
    endcase
  end

  // Pipeline next state. Flush beats stall. A stall freezes E and feeds M a bubble.
  always_comb begin
    e_d = e_q;
    m_d = '{regwrite: e_q.regwrite, memtoreg: e_q.memtoreg, memwrite: e_q.memwrite};
    w_d = '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg};
    if (bus.flush_e) begin
      e_d = '0;
    end else if (bus.stall_e) begin
      m_d = '0;
    end else begin
      e_d = dec_ctrl;
    end
  end

  // An illegal op counts only when it really enters Execute.
  assign illegal_evt = dec_illegal & ~bus.stall_e & ~bus.flush_e;

  // Error tracking next state. A clear wins over an event in the same cycle.
  always_comb begin
    seen_d = seen_q;
    cnt_d  = cnt_q;
    if (bus.clr_err) begin
      seen_d = 1'b0;
      cnt_d  = '0;
    end else if (illegal_evt) begin
      seen_d = 1'b1;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stage registers. Reset throws away every in-flight control immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Sticky illegal flag and saturating counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  // Decode strobes go back to Decode combinationally.
  assign bus.branch_d     = dec_branch;
  assign bus.bne_d        = dec_bne;
  assign bus.jump_d       = dec_jump;
  assign bus.illegal_d    = dec_illegal;

  assign bus.regwrite_e   = e_q.regwrite;
  assign bus.memtoreg_e   = e_q.memtoreg;
  assign bus.memwrite_e   = e_q.memwrite;
  assign bus.alusrc_e     = e_q.alusrc;
  assign bus.regdst_e     = e_q.regdst;
  assign bus.zeroext_e    = e_q.zeroext;
  assign bus.aluop_e      = e_q.aluop;

  assign bus.regwrite_m   = m_q.regwrite;
  assign bus.memtoreg_m   = m_q.memtoreg;
  assign bus.memwrite_m   = m_q.memwrite;

  assign bus.regwrite_w   = w_q.regwrite;
  assign bus.memtoreg_w   = w_q.memtoreg;

  assign bus.illegal_seen = seen_q;
  assign bus.illegal_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_ctrl_pipe
//  Description : Directed self-checking bench for mips_ctrl_pipe. dut_a has
//                the extended op set with an 8-bit counter. dut_b has the
//                base set with a 2-bit counter. Both DUTs see the same
//                stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_ctrl_pipe;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  mips_ctrl_pipe_if #(.EXT_OPS(1), .CNT_W(8)) bus_a ();
  mips_ctrl_pipe_if #(.EXT_OPS(0), .CNT_W(2)) bus_b ();

  mips_ctrl_pipe #(.EXT_OPS(1), .CNT_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  mips_ctrl_pipe #(.EXT_OPS(0), .CNT_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply the same Decode-side inputs to both DUTs
  task automatic drive(input logic [5:0] op, input logic st, input logic fl, input logic cl);
    bus_a.op_d = op; bus_a.stall_e = st; bus_a.flush_e = fl; bus_a.clr_err = cl;
    bus_b.op_d = op; bus_b.stall_e = st; bus_b.flush_e = fl; bus_b.clr_err = cl;
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    drive(OP_RTYPE, 1'b0, 1'b0, 1'b0);

    // Reset holds every stage at zero even with RTYPE presented
    repeat (2) @(posedge clk);
    #1;
    check("rst_regwrite_e", 32'(bus_a.regwrite_e), 32'd0);
    check("rst_regdst_e",   32'(bus_a.regdst_e),   32'd0);
    check("rst_regwrite_m", 32'(bus_a.regwrite_m), 32'd0);
    check("rst_cnt",        32'(bus_a.illegal_cnt), 32'd0);
    check("rst_seen",       32'(bus_a.illegal_seen), 32'd0);
    reset = 1'b1;

    // Streaming LW, SW, ADDI, RTYPE, BEQ
    drive(OP_LW, 1'b0, 1'b0, 1'b0);
    step();
    check("lw_regwrite_e", 32'(bus_a.regwrite_e), 32'd1);
    check("lw_memtoreg_e", 32'(bus_a.memtoreg_e), 32'd1);
    check("lw_alusrc_e",   32'(bus_a.alusrc_e),   32'd1);
    check("lw_aluop_e",    32'(bus_a.aluop_e),    32'd0);
    drive(OP_SW, 1'b0, 1'b0, 1'b0);
    step();
    check("sw_memwrite_e", 32'(bus_a.memwrite_e), 32'd1);
    check("sw_regwrite_e", 32'(bus_a.regwrite_e), 32'd0);
    check("lw_regwrite_m", 32'(bus_a.regwrite_m), 32'd1);
    check("lw_memtoreg_m", 32'(bus_a.memtoreg_m), 32'd1);
    drive(OP_ADDI, 1'b0, 1'b0, 1'b0);
    step();
    check("lw_regwrite_w",   32'(bus_a.regwrite_w), 32'd1);
    check("lw_memtoreg_w",   32'(bus_a.memtoreg_w), 32'd1);
    check("sw_memwrite_m",   32'(bus_a.memwrite_m), 32'd1);
    check("addi_memtoreg_e", 32'(bus_a.memtoreg_e), 32'd0);
    check("addi_regwrite_e", 32'(bus_a.regwrite_e), 32'd1);
    drive(OP_RTYPE, 1'b0, 1'b0, 1'b0);
    step();
    check("sw_regwrite_w",   32'(bus_a.regwrite_w), 32'd0);
    check("sw_memtoreg_w",   32'(bus_a.memtoreg_w), 32'd0);
    check("rtype_regdst_e",  32'(bus_a.regdst_e),   32'd1);
    check("rtype_aluop_e",   32'(bus_a.aluop_e),    32'd2);
    check("rtype_aluop_e_b", 32'(bus_b.aluop_e),    32'd2);
    check("addi_regwrite_m", 32'(bus_a.regwrite_m), 32'd1);
    drive(OP_BEQ, 1'b0, 1'b0, 1'b0);
    #1;
    check("beq_branch_d",   32'(bus_a.branch_d),  32'd1);
    check("beq_branch_d_b", 32'(bus_b.branch_d),  32'd1);
    check("beq_illegal_d",  32'(bus_a.illegal_d), 32'd0);
    step();
    check("beq_regwrite_e", 32'(bus_a.regwrite_e), 32'd0);
    check("beq_aluop_e",    32'(bus_a.aluop_e),    32'd1);
    check("beq_aluop_e_b",  32'(bus_b.aluop_e),    32'd1);
    check("addi_regwrite_w", 32'(bus_a.regwrite_w), 32'd1);
    check("addi_memtoreg_w", 32'(bus_a.memtoreg_w), 32'd0);

    // Stall for two edges with LW held in E, then flush together with stall
    drive(OP_LW, 1'b0, 1'b0, 1'b0);
    step();
    drive(OP_SW, 1'b1, 1'b0, 1'b0);
    step();
    check("stall1_memtoreg_e", 32'(bus_a.memtoreg_e), 32'd1);
    check("stall1_regwrite_m", 32'(bus_a.regwrite_m), 32'd0);
    step();
    check("stall2_memtoreg_e", 32'(bus_a.memtoreg_e), 32'd1);
    check("stall2_regwrite_m", 32'(bus_a.regwrite_m), 32'd0);
    check("stall2_regwrite_w", 32'(bus_a.regwrite_w), 32'd0);
    drive(OP_SW, 1'b1, 1'b1, 1'b0);
    step();
    check("flush_memtoreg_e", 32'(bus_a.memtoreg_e), 32'd0);
    check("flush_regwrite_e", 32'(bus_a.regwrite_e), 32'd0);
    check("flush_memtoreg_m", 32'(bus_a.memtoreg_m), 32'd1);
    check("flush_regwrite_m", 32'(bus_a.regwrite_m), 32'd1);
    drive(OP_RTYPE, 1'b0, 1'b0, 1'b0);
    step();
    check("flush_regwrite_w", 32'(bus_a.regwrite_w), 32'd1);
    check("flush_memtoreg_w", 32'(bus_a.memtoreg_w), 32'd1);
    check("base_cnt_b",       32'(bus_b.illegal_cnt), 32'd0);

    // Extended ops are legal on dut_a and illegal on dut_b
    drive(OP_ORI, 1'b0, 1'b0, 1'b0);
    #1;
    check("ori_illegal_d",   32'(bus_a.illegal_d), 32'd0);
    check("ori_illegal_d_b", 32'(bus_b.illegal_d), 32'd1);
    step();
    check("ori_aluop_e",      32'(bus_a.aluop_e),    32'd5);
    check("ori_zeroext_e",    32'(bus_a.zeroext_e),  32'd1);
    check("ori_alusrc_e",     32'(bus_a.alusrc_e),   32'd1);
    check("ori_regwrite_e_b", 32'(bus_b.regwrite_e), 32'd0);
    check("ori_alusrc_e_b",   32'(bus_b.alusrc_e),   32'd0);
    check("ori_zeroext_e_b",  32'(bus_b.zeroext_e),  32'd0);
    check("ori_cnt_b",        32'(bus_b.illegal_cnt), 32'd1);
    check("ori_seen_b",       32'(bus_b.illegal_seen), 32'd1);
    check("ori_cnt_a",        32'(bus_a.illegal_cnt), 32'd0);
    drive(OP_BNE, 1'b0, 1'b0, 1'b0);
    #1;
    check("bne_bne_d",    32'(bus_a.bne_d),    32'd1);
    check("bne_bne_d_b",  32'(bus_b.bne_d),    32'd0);
    check("bne_branch_d", 32'(bus_a.branch_d), 32'd0);
    step();
    check("bne_aluop_e", 32'(bus_a.aluop_e),     32'd1);
    check("bne_cnt_b",   32'(bus_b.illegal_cnt), 32'd2);
    drive(OP_J, 1'b0, 1'b0, 1'b0);
    #1;
    check("j_jump_d",   32'(bus_a.jump_d), 32'd1);
    check("j_jump_d_b", 32'(bus_b.jump_d), 32'd0);
    step();
    check("j_e_all_zero", 32'({bus_a.regwrite_e, bus_a.memtoreg_e, bus_a.memwrite_e,
                               bus_a.alusrc_e, bus_a.regdst_e, bus_a.zeroext_e,
                               bus_a.aluop_e}), 32'd0);
    check("j_cnt_b", 32'(bus_b.illegal_cnt), 32'd3);
    drive(OP_ANDI, 1'b0, 1'b0, 1'b0);
    step();
    check("andi_aluop_e",   32'(bus_a.aluop_e),     32'd4);
    check("andi_zeroext_e", 32'(bus_a.zeroext_e),   32'd1);
    check("andi_cnt_sat_b", 32'(bus_b.illegal_cnt), 32'd3);
    drive(OP_SLTI, 1'b0, 1'b0, 1'b0);
    step();
    check("slti_aluop_e",    32'(bus_a.aluop_e),      32'd7);
    check("slti_zeroext_e",  32'(bus_a.zeroext_e),    32'd0);
    check("slti_regwrite_e", 32'(bus_a.regwrite_e),   32'd1);
    check("slti_cnt_sat_b",  32'(bus_b.illegal_cnt),  32'd3);
    check("slti_seen_b",     32'(bus_b.illegal_seen), 32'd1);

    // Illegal opcode counting under normal, flush, stall and clear conditions
    drive(OP_BAD, 1'b0, 1'b0, 1'b0);
    #1;
    check("bad_illegal_d", 32'(bus_a.illegal_d), 32'd1);
    step();
    check("bad_cnt_a",      32'(bus_a.illegal_cnt),  32'd1);
    check("bad_seen_a",     32'(bus_a.illegal_seen), 32'd1);
    check("bad_regwrite_e", 32'(bus_a.regwrite_e),   32'd0);
    drive(OP_BAD, 1'b0, 1'b1, 1'b0);
    step();
    check("bad_flush_cnt_a", 32'(bus_a.illegal_cnt), 32'd1);
    drive(OP_BAD, 1'b1, 1'b0, 1'b0);
    step();
    check("bad_stall_cnt_a", 32'(bus_a.illegal_cnt), 32'd1);
    drive(OP_BAD, 1'b0, 1'b0, 1'b1);
    step();
    check("clr_cnt_a",  32'(bus_a.illegal_cnt),  32'd0);
    check("clr_seen_a", 32'(bus_a.illegal_seen), 32'd0);
    check("clr_cnt_b",  32'(bus_b.illegal_cnt),  32'd0);
    check("clr_seen_b", 32'(bus_b.illegal_seen), 32'd0);
    drive(OP_BAD, 1'b0, 1'b0, 1'b0);
    step();
    check("post_clr_cnt_a", 32'(bus_a.illegal_cnt), 32'd1);
    check("post_clr_cnt_b", 32'(bus_b.illegal_cnt), 32'd1);

    // Asynchronous reset mid-pipeline, then the first instruction after release
    drive(OP_LW, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_rst_regwrite_e", 32'(bus_a.regwrite_e), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_regwrite_e", 32'(bus_a.regwrite_e),   32'd0);
    check("arst_memtoreg_e", 32'(bus_a.memtoreg_e),   32'd0);
    check("arst_regwrite_m", 32'(bus_a.regwrite_m),   32'd0);
    check("arst_regwrite_w", 32'(bus_a.regwrite_w),   32'd0);
    check("arst_cnt_a",      32'(bus_a.illegal_cnt),  32'd0);
    check("arst_seen_a",     32'(bus_a.illegal_seen), 32'd0);
    check("arst_cnt_b",      32'(bus_b.illegal_cnt),  32'd0);
    #1;
    reset = 1'b1;
    drive(OP_ADDI, 1'b0, 1'b0, 1'b0);
    step();
    check("rel_regwrite_e", 32'(bus_a.regwrite_e), 32'd1);
    check("rel_alusrc_e",   32'(bus_a.alusrc_e),   32'd1);
    check("rel_regwrite_m", 32'(bus_a.regwrite_m), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
